// File: rtl/synchronous_ram_fifo_pkg.sv
// Shared helpers for synchronous_ram_fifo: pointer wrap function and almost-full margin.
package synchronous_ram_fifo_pkg;

  localparam int unsigned AlmostFullMargin = 1;

  // Advance a pointer by one, wrapping depth-1 back to 0 (depth need not be a power of two).
  function automatic int unsigned wrap_increment(input int unsigned pointer,
                                                 input int unsigned depth);
    return (pointer == depth - 1) ? 0 : pointer + 1;
  endfunction

endpackage

// File: rtl/simple_dual_port_ram.sv
// Single-clock RAM: one write port, one enabled registered read port.
// Only the read register is reset; the array contents are left as-is.
module simple_dual_port_ram #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned DEPTH         = 16,
  parameter int unsigned ADDRESS_WIDTH = $clog2(DEPTH)
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  input  logic                     write_enable_i,
  input  logic [ADDRESS_WIDTH-1:0] write_address_i,
  input  logic [WIDTH-1:0]         write_data_i,
  input  logic                     read_enable_i,
  input  logic [ADDRESS_WIDTH-1:0] read_address_i,
  output logic [WIDTH-1:0]         read_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] read_data_q;

  always_ff @(posedge clock_i) begin
    if (write_enable_i) begin
      mem_q[write_address_i] <= write_data_i;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      read_data_q <= '0;
    end else if (read_enable_i) begin
      read_data_q <= mem_q[read_address_i];
    end
  end

  assign read_data_o = read_data_q;

endmodule

// File: rtl/synchronous_ram_fifo.sv
// Valid/ready FIFO around a 1-cycle-latency RAM whose read register is the output stage.
// Define SYNCHRONOUS_RAM_FIFO_LEVEL_EN to add registered level_o and almost_full_o ports.
module synchronous_ram_fifo
  import synchronous_ram_fifo_pkg::*;
#(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned DEPTH         = 16,
  parameter int unsigned ADDRESS_WIDTH = $clog2(DEPTH),
  parameter int unsigned LEVEL_WIDTH   = $clog2(DEPTH + 2)
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   write_valid_i,
  input  logic [WIDTH-1:0]       write_data_i,
  output logic                   write_ready_o,
  output logic                   read_valid_o,
  output logic [WIDTH-1:0]       read_data_o,
`ifdef SYNCHRONOUS_RAM_FIFO_LEVEL_EN
  output logic [LEVEL_WIDTH-1:0] level_o,
  output logic                   almost_full_o,
`endif
  input  logic                   read_ready_i
);

  localparam int unsigned CountWidth = $clog2(DEPTH + 1);

  logic [ADDRESS_WIDTH-1:0] write_pointer_q, write_pointer_d;
  logic [ADDRESS_WIDTH-1:0] read_pointer_q, read_pointer_d;
  logic [CountWidth-1:0]    memory_count_q, memory_count_d;
  logic                     write_ready_q, write_ready_d;
  logic                     read_valid_q, read_valid_d;
  logic                     push, fetch;

  always_comb begin
    push  = write_valid_i && write_ready_q;
    // Fetch only from words already counted, so it never races a same-cycle write.
    fetch = (memory_count_q != '0) && (!read_valid_q || read_ready_i);

    write_pointer_d = write_pointer_q;
    if (push) begin
      write_pointer_d = ADDRESS_WIDTH'(wrap_increment(32'(write_pointer_q), DEPTH));
    end
    read_pointer_d = read_pointer_q;
    if (fetch) begin
      read_pointer_d = ADDRESS_WIDTH'(wrap_increment(32'(read_pointer_q), DEPTH));
    end

    memory_count_d = memory_count_q;
    if (push && !fetch) begin
      memory_count_d = memory_count_q + CountWidth'(1);
    end else if (fetch && !push) begin
      memory_count_d = memory_count_q - CountWidth'(1);
    end

    read_valid_d = read_valid_q;
    if (fetch) begin
      read_valid_d = 1'b1;
    end else if (read_ready_i) begin
      read_valid_d = 1'b0;
    end

    write_ready_d = (memory_count_d != CountWidth'(DEPTH));
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      write_pointer_q <= '0;
      read_pointer_q  <= '0;
      memory_count_q  <= '0;
      write_ready_q   <= 1'b0;
      read_valid_q    <= 1'b0;
    end else begin
      write_pointer_q <= write_pointer_d;
      read_pointer_q  <= read_pointer_d;
      memory_count_q  <= memory_count_d;
      write_ready_q   <= write_ready_d;
      read_valid_q    <= read_valid_d;
    end
  end

  simple_dual_port_ram #(
    .WIDTH         (WIDTH),
    .DEPTH         (DEPTH),
    .ADDRESS_WIDTH (ADDRESS_WIDTH)
  ) u_ram (
    .clock_i         (clock_i),
    .reset_i         (reset_i),
    .write_enable_i  (push),
    .write_address_i (write_pointer_q),
    .write_data_i    (write_data_i),
    .read_enable_i   (fetch),
    .read_address_i  (read_pointer_q),
    .read_data_o     (read_data_o)
  );

  assign write_ready_o = write_ready_q;
  assign read_valid_o  = read_valid_q;

`ifdef SYNCHRONOUS_RAM_FIFO_LEVEL_EN
  logic [LEVEL_WIDTH-1:0] level_q, level_d;
  logic                   almost_full_q, almost_full_d;

  always_comb begin
    level_d       = LEVEL_WIDTH'(memory_count_d) + LEVEL_WIDTH'(read_valid_d);
    almost_full_d = (level_d >= LEVEL_WIDTH'(DEPTH - AlmostFullMargin));
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      level_q       <= '0;
      almost_full_q <= 1'b0;
    end else begin
      level_q       <= level_d;
      almost_full_q <= almost_full_d;
    end
  end

  assign level_o       = level_q;
  assign almost_full_o = almost_full_q;
`endif

endmodule

// File: tb/tb_synchronous_ram_fifo.sv
// Scoreboard bench for synchronous_ram_fifo (DEPTH=16, WIDTH=8).
module tb_synchronous_ram_fifo;

  localparam int unsigned Width = 8;
  localparam int unsigned Depth = 16;
  localparam int unsigned LevelWidth = $clog2(Depth + 2);

  logic             clock;
  logic             reset;
  logic             write_valid;
  logic [Width-1:0] write_data;
  logic             write_ready;
  logic             read_valid;
  logic [Width-1:0] read_data;
  logic             read_ready;
`ifdef SYNCHRONOUS_RAM_FIFO_LEVEL_EN
  logic [LevelWidth-1:0] level;
  logic                  almost_full;
`endif

  int checks   = 0;
  int failures = 0;
  logic [Width-1:0] sb_q [$];
  logic             hold_valid = 1'b0;
  logic [Width-1:0] hold_data  = '0;

  synchronous_ram_fifo #(
    .WIDTH (Width),
    .DEPTH (Depth)
  ) dut (
    .clock_i       (clock),
    .reset_i       (reset),
    .write_valid_i (write_valid),
    .write_data_i  (write_data),
    .write_ready_o (write_ready),
    .read_valid_o  (read_valid),
    .read_data_o   (read_data),
`ifdef SYNCHRONOUS_RAM_FIFO_LEVEL_EN
    .level_o       (level),
    .almost_full_o (almost_full),
`endif
    .read_ready_i  (read_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Monitor: handshakes seen at negedge are the ones the next posedge will take.
  always @(negedge clock) begin
    if (reset) begin
      hold_valid = 1'b0;
    end else begin
      if (hold_valid) begin
        check("hold_valid", {31'b0, read_valid}, 32'd1);
        check("hold_data", {24'b0, read_data}, {24'b0, hold_data});
      end
      hold_valid = read_valid && !read_ready;
      hold_data  = read_data;
      if (write_valid && write_ready) sb_q.push_back(write_data);
      if (read_valid && read_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_underflow", 32'd1, 32'd0);
        end else begin
          check("sb_data", {24'b0, read_data}, {24'b0, sb_q.pop_front()});
        end
      end
    end
  end

  task automatic drain();
    read_ready  = 1'b1;
    write_valid = 1'b0;
    step();
    step();
    for (int k = 0; k < 40; k++) begin
      if (!read_valid) break;
      step();
    end
    check("drain_done", {31'b0, read_valid}, 32'd0);
    check("sb_empty", sb_q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic wr;
    reset       = 1'b1;
    write_valid = 1'b0;
    write_data  = '0;
    read_ready  = 1'b0;
    #1;
    check("rst_read_valid", {31'b0, read_valid}, 32'd0);
    check("rst_write_ready", {31'b0, write_ready}, 32'd0);
    check("rst_read_data", {24'b0, read_data}, 32'd0);
    step();
    step();
    reset = 1'b0;
    step();
    check("ready_after_rst", {31'b0, write_ready}, 32'd1);

    // First write into empty FIFO: 2-cycle latency.
    read_ready  = 1'b1;
    write_valid = 1'b1;
    write_data  = 8'hA5;
    step();
    write_valid = 1'b0;
    check("lat_not_yet", {31'b0, read_valid}, 32'd0);
    step();
    check("lat_valid", {31'b0, read_valid}, 32'd1);
    check("lat_data", {24'b0, read_data}, 32'h0000_00A5);
    step();
    check("lat_gone", {31'b0, read_valid}, 32'd0);

    // Fill with backpressure: DEPTH+1 words fit.
    read_ready = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      write_valid = 1'b1;
      write_data  = Width'(n);
      wr = write_ready;
      step();
      if (wr) n++;
    end
    write_valid = 1'b0;
    check("fill_count", n, 32'd17);
    check("fill_write_ready", {31'b0, write_ready}, 32'd0);
    check("fill_read_valid", {31'b0, read_valid}, 32'd1);
    check("fill_read_data", {24'b0, read_data}, 32'd0);
`ifdef SYNCHRONOUS_RAM_FIFO_LEVEL_EN
    check("fill_level", {27'b0, level}, 32'd17);
    check("fill_almost_full", {31'b0, almost_full}, 32'd1);
`endif

    // Drain in order, one per cycle; space frees right after the first read.
    read_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      check("drain_valid", {31'b0, read_valid}, 32'd1);
      check("drain_data", {24'b0, read_data}, i);
      step();
      if (i == 0) check("drain_ready_back", {31'b0, write_ready}, 32'd1);
    end
    check("drain_empty", {31'b0, read_valid}, 32'd0);

    // Random backpressure under a continuous write stream.
    n = 8'h40;
    for (int i = 0; i < 200; i++) begin
      write_valid = 1'b1;
      write_data  = Width'(n);
      read_ready  = 1'($urandom_range(0, 1));
      wr = write_ready;
      step();
      if (wr) n++;
    end
    drain();

    // Full-rate streaming while full, across pointer wrap.
    read_ready = 1'b0;
    n = 8'h80;
    for (int i = 0; i < 20; i++) begin
      write_valid = 1'b1;
      write_data  = Width'(n);
      wr = write_ready;
      step();
      if (wr) n++;
    end
    write_valid = 1'b0;
    read_ready  = 1'b1;
    step();
    for (int i = 0; i < 64; i++) begin
      write_valid = 1'b1;
      write_data  = Width'(n);
      check("rate_write_ready", {31'b0, write_ready}, 32'd1);
`ifdef SYNCHRONOUS_RAM_FIFO_LEVEL_EN
      check("rate_level", {27'b0, level}, 32'd16);
`endif
      step();
      n++;
    end
    drain();

    // Reset with words stored.
    read_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      write_valid = 1'b1;
      write_data  = Width'(8'hD0 + i);
      step();
    end
    write_valid = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    check("mid_rst_read_valid", {31'b0, read_valid}, 32'd0);
    check("mid_rst_write_ready", {31'b0, write_ready}, 32'd0);
    check("mid_rst_read_data", {24'b0, read_data}, 32'd0);
    sb_q.delete();
    step();
    step();
    reset = 1'b0;
    step();
    check("post_rst_write_ready", {31'b0, write_ready}, 32'd1);
    check("post_rst_read_valid", {31'b0, read_valid}, 32'd0);
`ifdef SYNCHRONOUS_RAM_FIFO_LEVEL_EN
    check("post_rst_level", {27'b0, level}, 32'd0);
`endif
    read_ready = 1'b1;
    step();
    step();
    check("post_rst_empty", {31'b0, read_valid}, 32'd0);
    write_valid = 1'b1;
    write_data  = 8'h3C;
    step();
    write_valid = 1'b0;
    step();
    check("post_rst_data", {24'b0, read_data}, 32'h0000_003C);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
